// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding,
// legal parameter ranges and small helpers used by the scheduler files.
package uart_tx_scheduler_pkg;

    typedef enum logic [1:0] {
        SYNC      = 2'd0,
        IDLE      = 2'd1,
        ISSUE     = 2'd2,
        WAIT_DONE = 2'd3
    } schedState_t;

    localparam int MIN_NUM_REQ       = 2;
    localparam int MAX_NUM_REQ       = 8;
    localparam int MIN_MEMORY_LENGTH = 1;

    // True when the requester count and message length are in the supported range.
    function automatic bit paramsValid(input int numReq, input int memoryLength);
        return (numReq >= MIN_NUM_REQ) && (numReq <= MAX_NUM_REQ) &&
               (memoryLength >= MIN_MEMORY_LENGTH);
    endfunction

    // Next requester index after idx, wrapping back to 0 past the last requester.
    function automatic int wrapIncrement(input int idx, input int numReq);
        return (idx + 1 >= numReq) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Bundle of the requester-side and transmitter-side signals of the scheduler.
// The master modport is the scheduler itself; the slave modport is the
// surrounding system (message sources plus the UART transmitter).
interface uart_tx_scheduler_if
    import uart_tx_scheduler_pkg::*;
#(
    parameter int NUM_REQ       = 3,
    parameter int MEMORY_LENGTH = 4
);

    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ*MEMORY_LENGTH*8-1:0] req_data;
    logic [NUM_REQ-1:0]                 req_ack;
    logic [MEMORY_LENGTH*8-1:0]         tx_data;
    logic                               tx_ready;
    logic                               tx_done;
    logic                               busy;
    logic [$clog2(NUM_REQ)-1:0]         grant_id;

    modport master (
        input  req_valid,
        input  req_data,
        input  tx_done,
        output req_ack,
        output tx_data,
        output tx_ready,
        output busy,
        output grant_id
    );

    modport slave (
        output req_valid,
        output req_data,
        output tx_done,
        input  req_ack,
        input  tx_data,
        input  tx_ready,
        input  busy,
        input  grant_id
    );

endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: starting at ptr and wrapping upward,
// the first active request wins. Produces a one-hot grant plus its index.
module rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grantIdx,
    output logic                       anyReq
);

    localparam int IDX_W = $clog2(NUM_REQ);

    int               cand;
    logic [IDX_W-1:0] candIdx;

    // Walk the requesters in priority order beginning at ptr and keep the first hit.
    always_comb begin
        grant    = '0;
        grantIdx = '0;
        anyReq   = 1'b0;
        cand     = 0;
        candIdx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            candIdx = IDX_W'(cand);
            if (!anyReq && req[candIdx]) begin
                anyReq         = 1'b1;
                grant[candIdx] = 1'b1;
                grantIdx       = candIdx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one multi-byte UART transmitter among several message sources.
// A round-robin winner's message is latched and handed to the transmitter;
// completion (data_written rising again) returns a one-cycle ack to the winner.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int NUM_REQ       = 3,
    parameter int MEMORY_LENGTH = 4,
    parameter int SYNC_CYCLES   = 28000000
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_scheduler_if.master  bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int MSG_W = MEMORY_LENGTH * 8;
    localparam int CNT_W = $clog2(SYNC_CYCLES + 1);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_CYCLES - 1);

    if (!paramsValid(NUM_REQ, MEMORY_LENGTH)) begin : gParamCheck
        $error("uart_tx_scheduler: NUM_REQ must be 2..8 and MEMORY_LENGTH at least 1");
    end

    schedState_t       state;
    schedState_t       nextState;
    logic              txReady;
    logic [CNT_W-1:0]  syncCount;
    logic [MSG_W-1:0]  txData;
    logic [MSG_W-1:0]  winData;
    logic [IDX_W-1:0]  rrPtr;
    logic [IDX_W-1:0]  grantId;
    logic [IDX_W-1:0]  winIdx;
    logic [NUM_REQ-1:0] winOneHot;
    logic [NUM_REQ-1:0] reqAck;
    logic              anyReq;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) uArbiter (
        .req      (bus.req_valid),
        .ptr      (rrPtr),
        .grant    (winOneHot),
        .grantIdx (winIdx),
        .anyReq   (anyReq)
    );

    // Select the winning requester's message with an AND-OR mux on the one-hot grant.
    always_comb begin
        winData = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winOneHot[i]) begin
                winData = winData | bus.req_data[i*MSG_W +: MSG_W];
            end
        end
    end

    // State register; reset always lands in SYNC so a transfer left running is never disturbed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SYNC;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode and the data_ready strobe, which is only raised in ISSUE.
    always_comb begin
        nextState = state;
        txReady   = 1'b0;
        case (state)
            SYNC: begin
                if (bus.tx_done || (syncCount == SYNC_LAST)) begin
                    nextState = IDLE;
                end
            end
            IDLE: begin
                if (anyReq) begin
                    nextState = ISSUE;
                end
            end
            ISSUE: begin
                txReady = 1'b1;
                if (!bus.tx_done) begin
                    nextState = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (bus.tx_done) begin
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = SYNC;
            end
        endcase
    end

    // SYNC timeout counter, only running while waiting for the transmitter to settle.
    always_ff @(posedge clk) begin
        if (rst) begin
            syncCount <= '0;
        end else if ((state == SYNC) && (nextState == SYNC)) begin
            syncCount <= syncCount + 1'b1;
        end else begin
            syncCount <= '0;
        end
    end

    // Latch the winner's message and index; tx_data must stay stable until completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            txData  <= '0;
            grantId <= '0;
        end else if ((state == IDLE) && anyReq) begin
            txData  <= winData;
            grantId <= winIdx;
        end
    end

    // On completion pulse the winner's ack and move priority to the next requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            reqAck <= '0;
            rrPtr  <= '0;
        end else begin
            reqAck <= '0;
            if ((state == WAIT_DONE) && bus.tx_done) begin
                reqAck <= NUM_REQ'(1) << grantId;
                rrPtr  <= IDX_W'(wrapIncrement(int'(grantId), NUM_REQ));
            end
        end
    end

    assign bus.tx_ready = txReady & ~rst;
    assign bus.busy     = rst | (state != IDLE);
    assign bus.tx_data  = txData;
    assign bus.req_ack  = reqAck;
    assign bus.grant_id = grantId;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Testbench for uart_tx_scheduler: a behavioural multi-byte transmitter that
// samples tx_data byte by byte, level requesters that retire after their acks,
// and a scoreboard monitor comparing emitted bytes and acks with queued values.
module tb_uart_tx_scheduler;

    localparam int NUM_REQ     = 3;
    localparam int ML          = 4;
    localparam int SYNC_CYCLES = 16;
    localparam int BYTE_CYCLES = 8;
    localparam int MSG_CYCLES  = ML * BYTE_CYCLES;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_tx_scheduler_if #(.NUM_REQ(NUM_REQ), .MEMORY_LENGTH(ML)) bus ();

    uart_tx_scheduler #(
        .NUM_REQ       (NUM_REQ),
        .MEMORY_LENGTH (ML),
        .SYNC_CYCLES   (SYNC_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [NUM_REQ*ML*8-1:0] reqData;
    logic [NUM_REQ-1:0]      reqValid;
    logic [NUM_REQ-1:0]      reqEnable = '0;
    int                      wanted[NUM_REQ]   = '{default: 0};
    int                      ackCount[NUM_REQ] = '{default: 0};

    logic       dataWritten = 1'b0;
    logic       modelBusy   = 1'b0;
    logic       byteStrobe  = 1'b0;
    logic [7:0] byteVal     = 8'h00;
    int         elapsed     = 0;

    logic [7:0] expByteQ[$];
    int         expAckQ[$];
    int         ackSeen      = 0;
    int         checksTotal  = 0;
    int         checksPassed = 0;
    int         expIdx;

    assign bus.req_valid = reqValid;
    assign bus.req_data  = reqData;
    assign bus.tx_done   = dataWritten;

    // A source stays valid while enabled and still owed acks.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            reqValid[i] = reqEnable[i] && (ackCount[i] < wanted[i]);
        end
    end

    // Transmitter model: accepts data_ready when idle, drops data_written, reads one byte per slot.
    always @(posedge clk) begin
        byteStrobe <= 1'b0;
        if (!modelBusy) begin
            if (bus.tx_ready) begin
                modelBusy   <= 1'b1;
                elapsed     <= 0;
                dataWritten <= 1'b0;
            end
        end else begin
            if ((elapsed % BYTE_CYCLES) == BYTE_CYCLES - 1) begin
                byteStrobe <= 1'b1;
                byteVal    <= bus.tx_data[(elapsed / BYTE_CYCLES) * 8 +: 8];
            end
            if (elapsed == MSG_CYCLES - 1) begin
                modelBusy   <= 1'b0;
                dataWritten <= 1'b1;
            end
            elapsed <= elapsed + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checksTotal++;
        if (actual === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Scoreboard monitor: bytes on the line, ack pulses with grant_id, and no data_ready into a busy UART.
    always @(negedge clk) begin
        if (byteStrobe) begin
            if (expByteQ.size() == 0) begin
                checksTotal++;
                $display("[TB] FAIL txByteUnexpected: got 0x%0h, expected no byte", byteVal);
            end else begin
                checkOutput("txByte", 64'(byteVal), 64'(expByteQ.pop_front()));
            end
        end
        if (bus.req_ack != '0) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_ack[i]) begin
                    ackCount[i] = ackCount[i] + 1;
                end
            end
            ackSeen = ackSeen + 1;
            if (expAckQ.size() == 0) begin
                checksTotal++;
                $display("[TB] FAIL reqAckUnexpected: got 0x%0h, expected no ack", bus.req_ack);
            end else begin
                expIdx = expAckQ.pop_front();
                checkOutput("reqAck", 64'(bus.req_ack), 64'(1) << expIdx);
                checkOutput("grantId", 64'(bus.grant_id), 64'(expIdx));
            end
        end
        if (bus.tx_ready) begin
            checkOutput("txReadyOverlap", 64'(modelBusy && (elapsed != 0)), 64'd0);
        end
    end

    task automatic expectMsg(input int idx, input logic [ML*8-1:0] msg, input bit withAck);
        for (int b = 0; b < ML; b++) begin
            expByteQ.push_back(msg[8*b +: 8]);
        end
        if (withAck) begin
            expAckQ.push_back(idx);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [ML*8-1:0] msg, input int count);
        reqData[idx*ML*8 +: ML*8] = msg;
        wanted[idx]    = wanted[idx] + count;
        reqEnable[idx] = 1'b1;
    endtask

    task automatic waitAcks(input int target);
        int budget;
        budget = 600;
        while ((ackSeen < target) && (budget > 0)) begin
            @(negedge clk);
            budget--;
        end
        checkOutput("ackCount", 64'(ackSeen), 64'(target));
    endtask

    task automatic applyReset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int cycles;
        reqData = {32'h34333231, 32'h64636261, 32'h44434241};

        // Reset values, transmitter never finished anything yet (data_written low)
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("resetReqAck", 64'(bus.req_ack), 64'd0);
        checkOutput("resetTxData", 64'(bus.tx_data), 64'd0);
        checkOutput("resetTxReady", 64'(bus.tx_ready), 64'd0);
        checkOutput("resetBusy", 64'(bus.busy), 64'd1);
        checkOutput("resetGrantId", 64'(bus.grant_id), 64'd0);
        rst = 1'b0;

        // SYNC times out after SYNC_CYCLES edges
        cycles = 0;
        while (bus.busy && (cycles < 100)) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("syncTimeout", 64'(cycles), 64'(SYNC_CYCLES));

        // Test 1: single request, first transfer after power-on
        expectMsg(0, 32'h44434241, 1'b1);
        applyStimulus(0, 32'h44434241, 1);
        waitAcks(1);

        // Test 2: all three valid from rr_ptr=0, requester 0 wants two messages
        applyReset(2);
        expectMsg(0, 32'h44434241, 1'b1);
        expectMsg(1, 32'h64636261, 1'b1);
        expectMsg(2, 32'h34333231, 1'b1);
        expectMsg(0, 32'h44434241, 1'b1);
        applyStimulus(0, 32'h44434241, 2);
        applyStimulus(1, 32'h64636261, 1);
        applyStimulus(2, 32'h34333231, 1);
        waitAcks(5);

        // Test 3: only requester 2 from rr_ptr=0, then 0 and 2 together
        applyReset(2);
        expectMsg(2, 32'h34333231, 1'b1);
        applyStimulus(2, 32'h34333231, 1);
        waitAcks(6);
        @(negedge clk);
        expectMsg(0, 32'h44434241, 1'b1);
        expectMsg(2, 32'h34333231, 1'b1);
        applyStimulus(0, 32'h44434241, 1);
        applyStimulus(2, 32'h34333231, 1);
        waitAcks(8);

        // Test 4: source data changes one cycle after grant; latched message goes out
        expectMsg(1, 32'h64636261, 1'b1);
        applyStimulus(1, 32'h64636261, 1);
        cycles = 0;
        while (!bus.busy && (cycles < 50)) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("grantBusy", 64'(bus.busy), 64'd1);
        @(negedge clk);
        reqData[1*ML*8 +: ML*8] = 32'hFFFFFFFF;
        waitAcks(9);

        // Test 5: reset in the middle of byte 2; UART finishes on cleared tx_data, no ack, clean retry
        expByteQ.push_back(8'h41);
        expByteQ.push_back(8'h42);
        expByteQ.push_back(8'h00);
        expByteQ.push_back(8'h00);
        expectMsg(0, 32'h44434241, 1'b1);
        applyStimulus(0, 32'h44434241, 1);
        cycles = 0;
        while (!(modelBusy && (elapsed == 2 * BYTE_CYCLES + 2)) && (cycles < 200)) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("midByte2Reached", 64'(elapsed), 64'(2 * BYTE_CYCLES + 2));
        rst = 1'b1;
        #1;
        checkOutput("txReadyInReset", 64'(bus.tx_ready), 64'd0);
        @(negedge clk);
        checkOutput("ackInReset", 64'(bus.req_ack), 64'd0);
        checkOutput("txReadyInReset2", 64'(bus.tx_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("syncHoldsBusy", 64'(bus.busy && modelBusy), 64'd1);
        waitAcks(10);

        // Test 6: requester 1 drops req_valid while waiting for completion
        expectMsg(1, 32'h78563412, 1'b1);
        applyStimulus(1, 32'h78563412, 1);
        cycles = 0;
        while (!(bus.busy && !bus.tx_ready && modelBusy && (elapsed >= 4)) && (cycles < 100)) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("waitDoneReached", 64'(bus.busy && !bus.tx_ready && modelBusy), 64'd1);
        reqEnable[1] = 1'b0;
        waitAcks(11);

        repeat (5) @(negedge clk);
        checkOutput("byteQueueDrained", 64'(expByteQ.size()), 64'd0);
        checkOutput("ackQueueDrained", 64'(expAckQ.size()), 64'd0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

    // Absolute time limit in case something stalls outside the bounded waits.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", checksPassed, checksTotal);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
